// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon Says game sequencer.
package simon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REARM = 3'd1,
    ST_SHOW  = 3'd2,
    ST_INPUT = 3'd3,
    ST_CHECK = 3'd4,
    ST_WIN   = 3'd5,
    ST_LOSE  = 3'd6
  } state_e;

  localparam int unsigned MAX_LEVEL_LIMIT = 10;
  localparam logic [3:0]  LEVEL_IDLE      = 4'd15;

  typedef logic [1:0] colour_t;

  // True when exactly one button bit is set.
  function automatic logic onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/simon_game_ctrl_if.sv
// Signal bundle between the game sequencer and its environment
// (button debouncers, pattern memory, LED blinker, status display).
interface simon_game_ctrl_if;
  logic       start;
  logic [3:0] btn;
  logic       blink_done;
  logic [3:0] blink_count;
  logic [1:0] mem_data;
  logic       blink_on_off;
  logic [3:0] blink_level;
  logic [3:0] mem_addr;
  logic [3:0] level_disp;
  logic       win;
  logic       lose;

  modport master (
    output start, btn, blink_done, blink_count, mem_data,
    input  blink_on_off, blink_level, mem_addr, level_disp, win, lose
  );

  modport slave (
    input  start, btn, blink_done, blink_count, mem_data,
    output blink_on_off, blink_level, mem_addr, level_disp, win, lose
  );
endinterface

// File: rtl/simon_timeout_timer.sv
// Per-press input window counter; only built when SIMON_INPUT_TIMEOUT_EN is defined.
`ifdef SIMON_INPUT_TIMEOUT_EN
module simon_timeout_timer #(
  parameter logic [39:0] LIMIT = 40'd1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [39:0] cnt_q, cnt_d;

  // Count cycles while enabled, saturating at the expiry point.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = 40'd0;
    end else if (enable_i && (cnt_q != LIMIT - 40'd1)) begin
      cnt_d = cnt_q + 40'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 40'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i && (cnt_q == LIMIT - 40'd1);

endmodule
`endif

// File: rtl/simon_game_ctrl.sv
// Simon Says game sequencer: replays the pattern, checks presses, tracks level/win/lose.
// Optional per-press timeout enabled by defining SIMON_INPUT_TIMEOUT_EN.
module simon_game_ctrl
  import simon_pkg::*;
#(
  parameter int unsigned MAX_LEVEL  = 10,
  parameter int unsigned ms         = 1_000_000,
  parameter int unsigned TIMEOUT_MS = 3000
) (
  input logic              clk,
  input logic              reset,
  simon_game_ctrl_if.slave bus
);

  localparam logic [3:0]  MAX_LVL        = 4'((MAX_LEVEL > MAX_LEVEL_LIMIT) ? MAX_LEVEL_LIMIT : MAX_LEVEL);
  localparam logic [39:0] TIMEOUT_CYCLES = 40'(TIMEOUT_MS) * 40'(ms);

  state_e     state_q, state_d;
  logic [3:0] level_q, level_d;
  logic [3:0] idx_q, idx_d;
  colour_t    colour_q, colour_d;
  logic       on_off_q, on_off_d;
  logic [3:0] blink_level_q, blink_level_d;
  logic [3:0] mem_addr_q, mem_addr_d;
  logic [3:0] level_disp_q, level_disp_d;
  logic       win_q, win_d;
  logic       lose_q, lose_d;

  colour_t    btn_colour_s;
  logic       btn_any_s;
  logic       btn_onehot_s;
  logic       expired_s;

  assign btn_any_s    = (bus.btn != 4'd0);
  assign btn_onehot_s = onehot4(bus.btn);

`ifdef SIMON_INPUT_TIMEOUT_EN
  simon_timeout_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   ((state_q != ST_INPUT) || btn_any_s),
    .enable_i  (state_q == ST_INPUT),
    .expired_o (expired_s)
  );
`else
  assign expired_s = (TIMEOUT_CYCLES == 40'd0) & 1'b0;
`endif

  // One-hot button to colour index.
  always_comb begin
    btn_colour_s = 2'd0;
    case (bus.btn)
      4'b0001: btn_colour_s = 2'd0;
      4'b0010: btn_colour_s = 2'd1;
      4'b0100: btn_colour_s = 2'd2;
      4'b1000: btn_colour_s = 2'd3;
      default: btn_colour_s = 2'd0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    idx_d    = idx_q;
    colour_d = colour_q;
    case (state_q)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (bus.start) begin
          level_d = 4'd1;
          state_d = ST_REARM;
        end else begin
          state_d = state_q;
        end
      end
      ST_REARM: begin
        idx_d   = 4'd0;
        state_d = ST_SHOW;
      end
      ST_SHOW: begin
        if (bus.blink_done) begin
          state_d = ST_INPUT;
        end else begin
          state_d = ST_SHOW;
        end
      end
      ST_INPUT: begin
        // A press on the expiry cycle takes priority over the timeout.
        if (btn_any_s) begin
          if (btn_onehot_s) begin
            colour_d = btn_colour_s;
            state_d  = ST_CHECK;
          end else begin
            state_d  = ST_LOSE;
          end
        end else if (expired_s) begin
          state_d = ST_LOSE;
        end else begin
          state_d = ST_INPUT;
        end
      end
      ST_CHECK: begin
        if (colour_q != bus.mem_data) begin
          state_d = ST_LOSE;
        end else if ((idx_q + 4'd1) < level_q) begin
          idx_d   = idx_q + 4'd1;
          state_d = ST_INPUT;
        end else if (level_q == MAX_LVL) begin
          state_d = ST_WIN;
        end else begin
          level_d = level_q + 4'd1;
          state_d = ST_REARM;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state so every output is a flop.
  always_comb begin
    on_off_d      = (state_d == ST_SHOW);
    mem_addr_d    = (state_d == ST_SHOW) ? bus.blink_count : idx_d;
    level_disp_d  = level_d;
    win_d         = (state_d == ST_WIN);
    lose_d        = (state_d == ST_LOSE);
    blink_level_d = level_d;
    case (state_d)
      ST_IDLE, ST_WIN, ST_LOSE: blink_level_d = LEVEL_IDLE;
      default:                  blink_level_d = level_d;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      level_q       <= 4'd0;
      idx_q         <= 4'd0;
      colour_q      <= 2'd0;
      on_off_q      <= 1'b0;
      blink_level_q <= LEVEL_IDLE;
      mem_addr_q    <= 4'd0;
      level_disp_q  <= 4'd0;
      win_q         <= 1'b0;
      lose_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      idx_q         <= idx_d;
      colour_q      <= colour_d;
      on_off_q      <= on_off_d;
      blink_level_q <= blink_level_d;
      mem_addr_q    <= mem_addr_d;
      level_disp_q  <= level_disp_d;
      win_q         <= win_d;
      lose_q        <= lose_d;
    end
  end

  assign bus.blink_on_off = on_off_q;
  assign bus.blink_level  = blink_level_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.level_disp   = level_disp_q;
  assign bus.win          = win_q;
  assign bus.lose         = lose_q;

endmodule

// File: tb/tb_simon_game_ctrl.sv
// Directed bench for simon_game_ctrl with a behavioural blinker and pattern memory.
module tb_simon_game_ctrl;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  logic [1:0] pattern [16];
  logic [1:0] tick_q;

  simon_game_ctrl_if bus ();

  simon_game_ctrl #(
    .MAX_LEVEL  (2),
    .ms         (1),
    .TIMEOUT_MS (20)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read pattern memory.
  always @(posedge clk) bus.mem_data <= pattern[bus.mem_addr];

  // Blinker model: one step every 4 cycles, done after blink_level steps.
  always @(posedge clk) begin
    if (!bus.blink_on_off) begin
      bus.blink_count <= 4'd0;
      bus.blink_done  <= 1'b0;
      tick_q          <= 2'd0;
    end else if (!bus.blink_done) begin
      tick_q <= tick_q + 2'd1;
      if (tick_q == 2'd3) begin
        if (bus.blink_count + 4'd1 == bus.blink_level) bus.blink_done <= 1'b1;
        else bus.blink_count <= bus.blink_count + 4'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic press(input logic [3:0] v);
    bus.btn = v;
    tick();
    bus.btn = 4'd0;
  endtask

  task automatic wait_show();
    int n = 0;
    while (!bus.blink_on_off && n < 200) begin
      tick();
      n++;
    end
    tests++;
    if (!bus.blink_on_off) begin
      fails++;
      $display("FAIL wait_show: blink_on_off=%0b after %0d cycles, required 1", bus.blink_on_off, n);
    end
  endtask

  task automatic wait_input();
    int n = 0;
    bit seen_high = bus.blink_on_off;
    bit done = 1'b0;
    while (!done && n < 200) begin
      tick();
      n++;
      if (bus.blink_on_off) seen_high = 1'b1;
      else if (seen_high) done = 1'b1;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL wait_input: replay did not finish in %0d cycles, required < 200", n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    tests++;
    if ({bus.blink_on_off, bus.blink_level, bus.mem_addr, bus.level_disp, bus.win, bus.lose} !== {1'b0, 4'd15, 4'd0, 4'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_values: on_off=%0b level=%0d addr=%0d disp=%0d win=%0b lose=%0b, required 0 15 0 0 0 0",
               bus.blink_on_off, bus.blink_level, bus.mem_addr, bus.level_disp, bus.win, bus.lose);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_win();
    pattern[0] = 2'd0;
    pattern[1] = 2'd1;
    pulse_start();
    tests++;
    if ({bus.blink_on_off, bus.level_disp, bus.blink_level} !== {1'b0, 4'd1, 4'd1}) begin
      fails++;
      $display("FAIL start_rearm: on_off=%0b disp=%0d level=%0d, required 0 1 1", bus.blink_on_off, bus.level_disp, bus.blink_level);
    end
    tick();
    tests++;
    if (bus.blink_on_off !== 1'b1) begin
      fails++;
      $display("FAIL start_latency: on_off=%0b, required 1", bus.blink_on_off);
    end
    wait_input();
    press(4'b0001);
    tick();
    tests++;
    if ({bus.blink_on_off, bus.level_disp, bus.blink_level} !== {1'b0, 4'd2, 4'd2}) begin
      fails++;
      $display("FAIL level_up: on_off=%0b disp=%0d level=%0d, required 0 2 2", bus.blink_on_off, bus.level_disp, bus.blink_level);
    end
    tick();
    tests++;
    if (bus.blink_on_off !== 1'b1) begin
      fails++;
      $display("FAIL rearm_one_cycle: on_off=%0b, required 1", bus.blink_on_off);
    end
    wait_input();
    press(4'b0001);
    tick();
    tests++;
    if (bus.win !== 1'b0) begin
      fails++;
      $display("FAIL win_early: win=%0b, required 0", bus.win);
    end
    press(4'b0010);
    tick();
    tests++;
    if ({bus.win, bus.lose, bus.blink_on_off, bus.blink_level, bus.level_disp} !== {1'b1, 1'b0, 1'b0, 4'd15, 4'd2}) begin
      fails++;
      $display("FAIL win: win=%0b lose=%0b on_off=%0b level=%0d disp=%0d, required 1 0 0 15 2",
               bus.win, bus.lose, bus.blink_on_off, bus.blink_level, bus.level_disp);
    end
  endtask

  task automatic test_wrong_colour();
    pattern[0] = 2'd2;
    pulse_start();
    tests++;
    if ({bus.win, bus.level_disp} !== {1'b0, 4'd1}) begin
      fails++;
      $display("FAIL restart_from_win: win=%0b disp=%0d, required 0 1", bus.win, bus.level_disp);
    end
    wait_input();
    press(4'b0001);
    tests++;
    if (bus.lose !== 1'b0) begin
      fails++;
      $display("FAIL lose_early: lose=%0b, required 0", bus.lose);
    end
    tick();
    tests++;
    if ({bus.lose, bus.blink_on_off, bus.blink_level} !== {1'b1, 1'b0, 4'd15}) begin
      fails++;
      $display("FAIL lose_wrong: lose=%0b on_off=%0b level=%0d, required 1 0 15", bus.lose, bus.blink_on_off, bus.blink_level);
    end
  endtask

  task automatic test_show_ignore_and_multibit();
    pattern[0] = 2'd0;
    pulse_start();
    tests++;
    if ({bus.lose, bus.level_disp} !== {1'b0, 4'd1}) begin
      fails++;
      $display("FAIL restart_from_lose: lose=%0b disp=%0d, required 0 1", bus.lose, bus.level_disp);
    end
    wait_show();
    press(4'b0101);
    press(4'b0001);
    pulse_start();
    tests++;
    if ({bus.blink_on_off, bus.lose, bus.level_disp} !== {1'b1, 1'b0, 4'd1}) begin
      fails++;
      $display("FAIL show_ignore: on_off=%0b lose=%0b disp=%0d, required 1 0 1", bus.blink_on_off, bus.lose, bus.level_disp);
    end
    wait_input();
    press(4'b0001);
    tick();
    tests++;
    if (bus.level_disp !== 4'd2) begin
      fails++;
      $display("FAIL idx_after_show: disp=%0d, required 2", bus.level_disp);
    end
    wait_input();
    press(4'b0101);
    tests++;
    if (bus.lose !== 1'b1) begin
      fails++;
      $display("FAIL multibit_lose: lose=%0b, required 1", bus.lose);
    end
  endtask

  task automatic test_reset_mid_show();
    pulse_start();
    wait_input();
    press(4'b0001);
    wait_show();
    tick();
    rst_n = 1'b0;
    #2;
    tests++;
    if ({bus.blink_on_off, bus.blink_level, bus.mem_addr, bus.level_disp, bus.win, bus.lose} !== {1'b0, 4'd15, 4'd0, 4'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL async_reset: on_off=%0b level=%0d addr=%0d disp=%0d win=%0b lose=%0b, required 0 15 0 0 0 0",
               bus.blink_on_off, bus.blink_level, bus.mem_addr, bus.level_disp, bus.win, bus.lose);
    end
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    tests++;
    if (bus.level_disp !== 4'd1) begin
      fails++;
      $display("FAIL start_after_reset: disp=%0d, required 1", bus.level_disp);
    end
  endtask

  task automatic test_timeout();
    wait_input();
`ifdef SIMON_INPUT_TIMEOUT_EN
    repeat (19) tick();
    tests++;
    if (bus.lose !== 1'b0) begin
      fails++;
      $display("FAIL timeout_early: lose=%0b, required 0", bus.lose);
    end
    tick();
    tests++;
    if (bus.lose !== 1'b1) begin
      fails++;
      $display("FAIL timeout_expire: lose=%0b, required 1", bus.lose);
    end
    pulse_start();
    wait_input();
    repeat (19) tick();
    press(4'b0001);
    tests++;
    if (bus.lose !== 1'b0) begin
      fails++;
      $display("FAIL press_on_expiry: lose=%0b, required 0", bus.lose);
    end
    tick();
    tests++;
    if (bus.level_disp !== 4'd2) begin
      fails++;
      $display("FAIL press_on_expiry_level: disp=%0d, required 2", bus.level_disp);
    end
`else
    repeat (1000) tick();
    tests++;
    if ({bus.lose, bus.blink_on_off} !== {1'b0, 1'b0}) begin
      fails++;
      $display("FAIL no_timeout: lose=%0b on_off=%0b, required 0 0", bus.lose, bus.blink_on_off);
    end
    press(4'b0001);
    tick();
    tests++;
    if (bus.level_disp !== 4'd2) begin
      fails++;
      $display("FAIL late_press: disp=%0d, required 2", bus.level_disp);
    end
`endif
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.btn = 4'd0;
    for (int i = 0; i < 16; i++) pattern[i] = 2'd0;
    test_reset();
    test_win();
    test_wrong_colour();
    test_show_ignore_and_multibit();
    test_reset_mid_show();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
